// File: rtl/debug_frame_receiver_if.sv
// FIFO-side handshake of the debug frame receiver: first-word-fall-through head byte,
// non-empty flag and the single-cycle pop strobe.
interface debug_frame_receiver_if;
  logic [7:0] fifoData;
  logic       dataAvailable;
  logic       readFlag;

  modport master (output fifoData, output dataAvailable, input readFlag);
  modport slave  (input fifoData, input dataAvailable, output readFlag);
endinterface

// File: rtl/debug_frame_receiver.sv
// Decodes SYNC/LEN/payload/CHK frames popped from a UART RX FIFO into a word buffer,
// validating length and XOR checksum, with a registered read port onto the buffer.
module debug_frame_receiver #(
  parameter int          MAX_WORDS      = 64,
  parameter int          ADDR_W         = 6,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic                clock,
  input  logic                reset,
  debug_frame_receiver_if.slave fifo,
  input  logic [ADDR_W-1:0]   rdAddr,
  output logic [31:0]         rdData,
  output logic [7:0]          wordCount,
  output logic                frameDone,
  output logic                frameError,
  output logic [1:0]          errorCode,
  output logic                busy
);

  localparam int               TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]       MAXW_B = 8'(MAX_WORDS);

  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHECK} state_t;

  state_t           r_state, w_next;
  logic             r_rd_prev;
  logic [TMO_W-1:0] r_tmo;
  logic [7:0]       r_idx;
  logic [1:0]       r_bcnt;
  logic [7:0]       r_len;
  logic [7:0]       r_chk;
  logic [31:0]      r_asm;
  logic             r_done, r_err;
  logic [1:0]       r_ec;
  logic [7:0]       r_wc;
  logic [31:0]      r_buf [MAX_WORDS];

  logic        w_timeout, w_accept, w_len_ok, w_pay_acc, w_word_done, w_last_word;
  logic        w_len_acc;
  logic [7:0]  w_byte, w_idx_nxt;
  logic [31:0] w_word;
  logic        w_done_set, w_err_set;
  logic [1:0]  w_err_code;

  // The pending byte is left in the FIFO on the timeout cycle; nothing pops during reset.
  assign w_timeout   = (r_state != S_HUNT) && (r_tmo == TMO_LIM);
  assign w_accept    = fifo.dataAvailable && !r_rd_prev && !w_timeout && !reset;
  assign fifo.readFlag = w_accept;

  assign w_byte      = fifo.fifoData;
  assign w_len_ok    = (w_byte != 8'd0) && (w_byte <= MAXW_B);
  assign w_len_acc   = (r_state == S_LEN) && w_accept && w_len_ok;
  assign w_pay_acc   = (r_state == S_PAYLOAD) && w_accept;
  assign w_word      = {r_asm[23:0], w_byte};
  assign w_idx_nxt   = r_idx + 8'd1;
  assign w_word_done = w_pay_acc && (r_bcnt == 2'd3);
  assign w_last_word = w_word_done && (w_idx_nxt == r_len);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_HUNT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_HUNT:    if (w_accept && (w_byte == SYNC_BYTE)) w_next = S_LEN;
      S_LEN:     if (w_timeout) w_next = S_HUNT;
                 else if (w_accept) w_next = w_len_ok ? S_PAYLOAD : S_HUNT;
      S_PAYLOAD: if (w_timeout) w_next = S_HUNT;
                 else if (w_last_word) w_next = S_CHECK;
      S_CHECK:   if (w_timeout || w_accept) w_next = S_HUNT;
      default:   w_next = S_HUNT;
    endcase
  end

  always_comb begin
    w_done_set = 1'b0;
    w_err_set  = 1'b0;
    w_err_code = r_ec;
    if (w_timeout) begin
      w_err_set  = 1'b1;
      w_err_code = 2'd3;
    end else if (w_accept) begin
      if (r_state == S_LEN && !w_len_ok) begin
        w_err_set  = 1'b1;
        w_err_code = 2'd1;
      end else if (r_state == S_CHECK) begin
        if (w_byte == r_chk) w_done_set = 1'b1;
        else begin
          w_err_set  = 1'b1;
          w_err_code = 2'd2;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_prev <= 1'b0;
      r_tmo     <= '0;
      r_idx     <= 8'd0;
      r_bcnt    <= 2'd0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_ec      <= 2'd0;
      r_wc      <= 8'd0;
    end else begin
      r_rd_prev <= w_accept;
      r_tmo     <= (r_state == S_HUNT || w_accept) ? '0 : r_tmo + 1'b1;
      r_done    <= w_done_set;
      r_err     <= w_err_set;
      if (w_err_set) r_ec <= w_err_code;
      if (w_len_acc) begin
        r_wc   <= 8'd0;
        r_idx  <= 8'd0;
        r_bcnt <= 2'd0;
      end
      if (w_pay_acc) r_bcnt <= r_bcnt + 2'd1;
      if (w_word_done) r_idx <= w_idx_nxt;
      if (w_done_set) r_wc <= r_len;
    end
  end

  // Frame datapath: assembly register, checksum and latched length carry no reset.
  always_ff @(posedge clock) begin
    if (w_len_acc) begin
      r_len <= w_byte;
      r_chk <= 8'd0;
    end
    if (w_pay_acc) begin
      r_asm <= w_word;
      r_chk <= r_chk ^ w_byte;
    end
  end

  always_ff @(posedge clock) begin
    if (w_word_done) r_buf[r_idx[ADDR_W-1:0]] <= w_word;
  end

  // Read samples the array before this edge's write lands, so a colliding read sees old data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rdData <= 32'd0;
    else       rdData <= r_buf[rdAddr];
  end

  assign wordCount  = r_wc;
  assign frameDone  = r_done;
  assign frameError = r_err;
  assign errorCode  = r_ec;
  assign busy       = (r_state != S_HUNT);

endmodule

// File: tb/tb_debug_frame_receiver.sv
// Randomized and directed bench for debug_frame_receiver against a byte-stream frame parser model.
module tb_debug_frame_receiver;
  localparam int         MAXW = 64;
  localparam int         TMO  = 300;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  rdAddr = '0;
  logic [31:0] rdData;
  logic [7:0]  wordCount;
  logic        frameDone, frameError, busy;
  logic [1:0]  errorCode;

  debug_frame_receiver_if fif ();

  debug_frame_receiver #(.MAX_WORDS(MAXW), .ADDR_W(6), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .fifo(fif), .rdAddr(rdAddr), .rdData(rdData),
    .wordCount(wordCount), .frameDone(frameDone), .frameError(frameError),
    .errorCode(errorCode), .busy(busy)
  );

  always #5 clock = ~clock;

  int          n_total = 0;
  int          n_bad   = 0;
  int          n_pops  = 0;
  logic        prev_rf = 1'b0;
  logic        stall   = 1'b0;
  logic [7:0]  q[$];
  logic [7:0]  stim[$];
  logic [31:0] obs_ev[$];
  logic [31:0] exp_ev[$];
  logic [31:0] m_words[$];
  logic [7:0]  m_wc = 8'd0;
  logic [1:0]  m_ec = 2'd0;
  logic        m_good = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic gate;
    gate = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    fif.dataAvailable = (q.size() != 0) && gate;
    fif.fifoData      = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // One clock: observe mid-cycle, pop the FIFO model after the edge if the DUT consumed the head.
  task automatic step();
    logic rf;
    @(negedge clock);
    rf = fif.readFlag;
    if (rf) begin
      n_pops++;
      chk("rf_gap", {31'd0, prev_rf}, 32'd0);
    end
    prev_rf = rf;
    if (frameDone || frameError) begin
      chk("done_err_excl", {31'd0, frameDone & frameError}, 32'd0);
      if (frameDone) obs_ev.push_back(32'h0100 | {24'd0, wordCount});
      else           obs_ev.push_back(32'h0200 | {30'd0, errorCode});
    end
    @(posedge clock);
    #1;
    if (rf && q.size() != 0) void'(q.pop_front());
    drive();
  endtask

  // Reference: walks the byte list by the framing rules and lists the expected outcomes.
  task automatic model(input logic [7:0] bs[$]);
    int i, n, L;
    logic [7:0]  c;
    logic [31:0] w;
    logic [31:0] words[$];
    i = 0;
    n = bs.size();
    while (i < n) begin
      if (bs[i] != SYNC) begin
        i++;
        continue;
      end
      i++;
      if (i >= n) break;
      L = int'(bs[i]);
      i++;
      if (L == 0 || L > MAXW) begin
        exp_ev.push_back(32'h0201);
        m_ec = 2'd1;
        m_good = 1'b0;
        continue;
      end
      m_wc = 8'd0;
      if (i + 4 * L >= n) break;
      c = 8'd0;
      words.delete();
      for (int k = 0; k < L; k++) begin
        w = {bs[i+4*k], bs[i+4*k+1], bs[i+4*k+2], bs[i+4*k+3]};
        c = c ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        words.push_back(w);
      end
      if (bs[i+4*L] == c) begin
        exp_ev.push_back(32'h0100 | L);
        m_wc = 8'(L);
        m_words = words;
        m_good = 1'b1;
      end else begin
        exp_ev.push_back(32'h0202);
        m_ec = 2'd2;
        m_good = 1'b0;
      end
      i += 4 * L + 1;
    end
  endtask

  task automatic add_frame(input int L, input bit corrupt);
    logic [7:0] b, c;
    c = 8'd0;
    stim.push_back(SYNC);
    stim.push_back(8'(L));
    for (int k = 0; k < 4 * L; k++) begin
      b = 8'($urandom_range(0, 255));
      c ^= b;
      stim.push_back(b);
    end
    stim.push_back(corrupt ? (c ^ 8'(1 << $urandom_range(0, 7))) : c);
  endtask

  task automatic add_garbage(input int n);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      do b = 8'($urandom_range(0, 255)); while (b == SYNC);
      stim.push_back(b);
    end
  endtask

  task automatic read_word(input int a, output logic [31:0] d);
    rdAddr = 6'(a);
    @(posedge clock);
    #1;
    d = rdData;
  endtask

  task automatic run_stream(input string tag);
    int cyc, budget;
    logic [31:0] d;
    obs_ev.delete();
    exp_ev.delete();
    model(stim);
    foreach (stim[k]) q.push_back(stim[k]);
    budget = stim.size() * 8 + 50;
    stim.delete();
    drive();
    cyc = 0;
    while ((q.size() != 0 || busy) && cyc < budget) begin
      step();
      cyc++;
    end
    if (cyc >= budget) chk({tag, "_drain"}, q.size(), 32'd0);
    repeat (3) step();
    chk({tag, "_nev"}, obs_ev.size(), exp_ev.size());
    for (int k = 0; k < obs_ev.size() && k < exp_ev.size(); k++)
      chk({tag, "_ev"}, obs_ev[k], exp_ev[k]);
    chk({tag, "_wc"}, {24'd0, wordCount}, {24'd0, m_wc});
    chk({tag, "_ec"}, {30'd0, errorCode}, {30'd0, m_ec});
    if (m_good)
      for (int k = 0; k < m_words.size(); k++) begin
        read_word(k, d);
        chk({tag, "_buf"}, d, m_words[k]);
      end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, w0;
    int k, cyc;
    fif.dataAvailable = 1'b0;
    fif.fifoData = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rf", {31'd0, fif.readFlag}, 32'd0);
    chk("rst_outs", {rdData[7:0], wordCount, 5'd0, frameDone, frameError, busy, 6'd0, errorCode}, 32'd0);
    reset = 1'b0;

    // Payload XOR of the first frame works out to 0x66.
    n_pops = 0;
    stim = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h66};
    run_stream("good");
    chk("good_pops", n_pops, 32'd11);
    chk("good_wc", {24'd0, wordCount}, 32'd2);
    read_word(0, d);  chk("good_b0", d, 32'h11223344);
    read_word(1, d);  chk("good_b1", d, 32'hDEADBEEF);

    stim = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    run_stream("garb");
    read_word(0, d);  chk("garb_b0", d, 32'h01020304);

    stim = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_stream("badchk");
    chk("badchk_ec", {30'd0, errorCode}, 32'd2);
    chk("badchk_wc", {24'd0, wordCount}, 32'd0);
    stim = '{8'hA5, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'hF0};
    run_stream("after_bad");

    stim = '{8'hA5, 8'h00};
    run_stream("len0");
    chk("len0_busy", {31'd0, busy}, 32'd0);
    stim = '{8'hA5, 8'h41};
    run_stream("len65");
    chk("len65_ec", {30'd0, errorCode}, 32'd1);
    stall = 1'b1;
    add_frame(MAXW, 1'b0);
    run_stream("len64");
    stall = 1'b0;

    // Timeout: frame header then silence.
    obs_ev.delete();
    q.push_back(8'hA5);
    q.push_back(8'h03);
    drive();
    cyc = 0;
    while (q.size() != 0 && cyc < 50) begin step(); cyc++; end
    chk("tmo_busy", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (obs_ev.size() == 0 && cyc < TMO + 50) begin step(); cyc++; end
    chk("tmo_lat", {31'd0, (cyc >= TMO && cyc <= TMO + 4)}, 32'd1);
    chk("tmo_ev", (obs_ev.size() != 0) ? obs_ev[0] : 32'h0, 32'h0203);
    chk("tmo_busy0", {31'd0, busy}, 32'd0);
    m_ec = 2'd3;
    m_wc = 8'd0;
    m_good = 1'b0;
    stim = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    run_stream("late");

    for (int r = 0; r < 6; r++) begin
      stall = $urandom_range(0, 1);
      for (int s = 0; s < 8; s++) begin
        k = $urandom_range(0, 9);
        if (k < 2)       add_garbage($urandom_range(1, 3));
        else if (k < 6)  add_frame($urandom_range(1, 6), 1'b0);
        else if (k < 8)  add_frame($urandom_range(1, 4), 1'b1);
        else begin
          stim.push_back(SYNC);
          stim.push_back((k == 8) ? 8'h00 : 8'($urandom_range(MAXW + 1, 255)));
        end
      end
      add_frame($urandom_range(1, 5), 1'b0);
      run_stream("rand");
    end
    stall = 1'b0;

    // Reset in the middle of a payload.
    n_pops = 0;
    add_frame(2, 1'b0);
    foreach (stim[j]) q.push_back(stim[j]);
    stim.delete();
    drive();
    cyc = 0;
    while (n_pops < 7 && cyc < 50) begin step(); cyc++; end
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("rstmid_rf", {31'd0, fif.readFlag}, 32'd0);
      chk("rstmid_outs", {rdData[7:0], wordCount, 5'd0, frameDone, frameError, busy, 6'd0, errorCode}, 32'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    prev_rf = 1'b0;
    q.delete();
    m_wc = 8'd0;
    m_ec = 2'd0;
    m_good = 1'b0;
    add_frame(2, 1'b0);
    run_stream("post_rst");
    read_word(0, w0);
    rdAddr = 6'd1;
    #1;
    chk("rd_lat_hold", rdData, w0);
    @(posedge clock);
    #1;
    chk("rd_lat_new", rdData, m_words[1]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
